// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin arbiter and 4-cycle sequencer
// for the shared peripheral bus, with registered per-master read data and ack.
module periph_bus_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W/8-1:0] m0_be,
   input  logic [DATA_W-1:0]   m0_wdata,
   output logic                m0_ack,
   output logic [DATA_W-1:0]   m0_rdata,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W/8-1:0] m1_be,
   input  logic [DATA_W-1:0]   m1_wdata,
   output logic                m1_ack,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [ADDR_W-1:0]   addr,
   output logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   wdata,
   output logic                we,
   input  logic [DATA_W-1:0]   q,
   output logic                busy,
   output logic                owner
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
   logic [1:0] state;
   logic       last_grant, lat_we, gnt;
   // on a tie the master that did not win last time gets the bus
   always_comb gnt = (m0_req & m1_req) ? ~last_grant : m1_req;
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state      <= IDLE;
         addr       <= '0;
         be         <= '0;
         wdata      <= '0;
         we         <= 1'b0;
         lat_we     <= 1'b0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else
         case (state)
            IDLE:
               if (m0_req | m1_req) begin
                  state      <= ISSUE;
                  owner      <= gnt;
                  last_grant <= gnt;
                  lat_we     <= gnt ? m1_we : m0_we;
                  we         <= gnt ? m1_we : m0_we;
                  addr       <= gnt ? m1_addr : m0_addr;
                  be         <= gnt ? m1_be : m0_be;
                  wdata      <= gnt ? m1_wdata : m0_wdata;
               end
            ISSUE: begin
               we    <= 1'b0;
               state <= WAIT;
            end
            WAIT: begin
               if (!lat_we && !owner) m0_rdata <= q;
               if (!lat_we && owner) m1_rdata <= q;
               m0_ack <= ~owner;
               m1_ack <= owner;
               addr   <= '0;
               be     <= '0;
               wdata  <= '0;
               state  <= DONE;
            end
            default: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
               state  <= IDLE;
            end
         endcase
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-timeline reference model.
module tb_periph_bus_arbiter;
   logic        clk = 1'b0, rst = 1'b0;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [7:0]  m0_addr = 0, m1_addr = 0;
   logic [3:0]  m0_be = 0, m1_be = 0;
   logic [31:0] m0_wdata = 0, m1_wdata = 0, q = 0;
   logic        m0_ack, m1_ack, we, busy, owner;
   logic [31:0] m0_rdata, m1_rdata, wdata;
   logic [7:0]  addr;
   logic [3:0]  be;
   int          tests = 0, fails = 0, cyc = 0;

   periph_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .addr(addr), .be(be), .wdata(wdata), .we(we), .q(q), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset;
      m0_req = 0;
      m1_req = 0;
      q = 0;
      rst = 0;
      tick;
      tick;
      rst = 1;
   endtask

   task automatic test_reset;
      rst = 0;
      #1;
      tests++;
      if ({addr, be, wdata, we, m0_ack, m1_ack, m0_rdata, m1_rdata, busy, owner} !== '0) begin
         fails++;
         $display("FAIL reset_async: got addr=%h be=%h wdata=%h we=%b ack=%b%b busy=%b owner=%b, required all 0",
                  addr, be, wdata, we, m1_ack, m0_ack, busy, owner);
      end
      tick;
      tests++;
      if ({addr, be, wdata, we, m0_ack, m1_ack, m0_rdata, m1_rdata, busy, owner} !== '0) begin
         fails++;
         $display("FAIL reset_clocked: outputs not all 0 (addr=%h we=%b busy=%b)", addr, we, busy);
      end
   endtask

   task automatic test_single_write;
      do_reset;
      m0_we = 1; m0_addr = 8'h95; m0_be = 4'hF; m0_wdata = 32'h00508113; m0_req = 1;
      tick;
      tests++;
      if ({we, addr, be, wdata, owner, busy} !== {1'b1, 8'h95, 4'hF, 32'h00508113, 1'b0, 1'b1}) begin
         fails++;
         $display("FAIL wr_issue: got we=%b addr=%h be=%h wdata=%h owner=%b busy=%b, required 1 95 f 00508113 0 1",
                  we, addr, be, wdata, owner, busy);
      end
      tick;
      tests++;
      if ({we, addr, m0_ack} !== {1'b0, 8'h95, 1'b0}) begin
         fails++;
         $display("FAIL wr_wait: got we=%b addr=%h ack=%b, required 0 95 0", we, addr, m0_ack);
      end
      tick;
      tests++;
      if ({m0_ack, m1_ack, addr, we} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
         fails++;
         $display("FAIL wr_done: got m0_ack=%b m1_ack=%b addr=%h we=%b, required 1 0 00 0", m0_ack, m1_ack, addr, we);
      end
      m0_req = 0;
      tick;
      tests++;
      if ({m0_ack, busy} !== 2'b00) begin
         fails++;
         $display("FAIL wr_idle: got m0_ack=%b busy=%b, required 0 0", m0_ack, busy);
      end
   endtask

   task automatic test_single_read;
      logic we_seen = 0;
      do_reset;
      q = 32'h55507093;
      m1_we = 0; m1_addr = 8'hFF; m1_be = 4'hF; m1_req = 1;
      for (int k = 1; k <= 3; k++) begin
         tick;
         we_seen |= we;
         if (k == 1) begin
            tests++;
            if ({addr, owner} !== {8'hFF, 1'b1}) begin
               fails++;
               $display("FAIL rd_issue: got addr=%h owner=%b, required ff 1", addr, owner);
            end
         end
      end
      tests++;
      if ({m1_ack, m0_ack, m1_rdata, m0_rdata} !== {1'b1, 1'b0, 32'h55507093, 32'h0}) begin
         fails++;
         $display("FAIL rd_done: got m1_ack=%b m0_ack=%b m1_rdata=%h m0_rdata=%h, required 1 0 55507093 00000000",
                  m1_ack, m0_ack, m1_rdata, m0_rdata);
      end
      m1_req = 0;
      tick;
      we_seen |= we;
      tests++;
      if (we_seen !== 1'b0) begin
         fails++;
         $display("FAIL rd_no_we: got we asserted during read, required never");
      end
   endtask

   task automatic test_contention;
      logic e0, e1, eo;
      m0_req = 0; m1_req = 0; rst = 0;
      tick;
      m0_we = 0; m0_addr = 8'h11; m1_we = 0; m1_addr = 8'h22;
      m0_req = 1; m1_req = 1;
      rst = 1;
      for (int k = 1; k <= 16; k++) begin
         tick;
         e0 = (k % 4 == 3) && ((k / 4) % 2 == 0);
         e1 = (k % 4 == 3) && ((k / 4) % 2 == 1);
         eo = 1'(((k - 1) / 4) % 2);
         tests++;
         if ({m0_ack, m1_ack, owner} !== {e0, e1, eo}) begin
            fails++;
            $display("FAIL contention k=%0d: got ack0=%b ack1=%b owner=%b, required %b %b %b",
                     k, m0_ack, m1_ack, owner, e0, e1, eo);
         end
      end
      m0_req = 0; m1_req = 0;
      tick;
   endtask

   task automatic test_late_requester;
      do_reset;
      m0_we = 0; m0_addr = 8'h20; m0_req = 1;
      tick;
      tick;
      m1_we = 1; m1_addr = 8'h40; m1_be = 4'h3; m1_wdata = 32'hCAFE0001; m1_req = 1;
      tick;
      tests++;
      if ({m0_ack, m1_ack, owner} !== 3'b100) begin
         fails++;
         $display("FAIL late_m0_done: got ack0=%b ack1=%b owner=%b, required 1 0 0", m0_ack, m1_ack, owner);
      end
      m0_req = 0;
      tick;
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL late_idle: got busy=%b, required 0", busy);
      end
      tick;
      tests++;
      if ({we, addr, be, wdata, owner} !== {1'b1, 8'h40, 4'h3, 32'hCAFE0001, 1'b1}) begin
         fails++;
         $display("FAIL late_m1_issue: got we=%b addr=%h be=%h wdata=%h owner=%b, required 1 40 3 cafe0001 1",
                  we, addr, be, wdata, owner);
      end
      tick;
      tick;
      tests++;
      if ({m1_ack, m0_ack} !== 2'b10) begin
         fails++;
         $display("FAIL late_m1_done: got ack1=%b ack0=%b, required 1 0", m1_ack, m0_ack);
      end
      m1_req = 0;
      tick;
   endtask

   task automatic test_async_reset;
      logic ack_seen = 0;
      do_reset;
      q = 32'hA5A5A5A5;
      m0_we = 0; m0_addr = 8'h10; m0_req = 1;
      tick;
      tick;
      #2 rst = 0;
      #1;
      tests++;
      if ({addr, be, wdata, we, m0_ack, m1_ack, m0_rdata, m1_rdata, busy, owner} !== '0) begin
         fails++;
         $display("FAIL arst_now: got addr=%h we=%b busy=%b rdata0=%h, required all 0", addr, we, busy, m0_rdata);
      end
      m1_req = 1;
      for (int k = 0; k < 3; k++) begin
         tick;
         ack_seen |= m0_ack | m1_ack;
      end
      tests++;
      if (ack_seen !== 1'b0) begin
         fails++;
         $display("FAIL arst_no_ack: got an ack during/after reset, required none");
      end
      rst = 1;
      tick;
      tests++;
      if ({owner, busy, we} !== 3'b010) begin
         fails++;
         $display("FAIL arst_tie: got owner=%b busy=%b we=%b, required 0 1 0", owner, busy, we);
      end
      tick;
      tick;
      tests++;
      if ({m0_ack, m1_ack} !== 2'b10) begin
         fails++;
         $display("FAIL arst_tie_done: got ack0=%b ack1=%b, required 1 0", m0_ack, m1_ack);
      end
      m0_req = 0; m1_req = 0;
      tick;
   endtask

   task automatic test_rdata_hold;
      do_reset;
      q = 32'h1234ABCD;
      m0_we = 0; m0_addr = 8'h30; m0_req = 1;
      tick; tick; tick;
      tests++;
      if ({m0_ack, m0_rdata} !== {1'b1, 32'h1234ABCD}) begin
         fails++;
         $display("FAIL hold_read: got ack=%b rdata=%h, required 1 1234abcd", m0_ack, m0_rdata);
      end
      m0_req = 0;
      tick;
      q = 32'hDEADBEEF;
      m0_we = 1; m0_be = 4'h0; m0_wdata = 32'h0BADF00D; m0_req = 1;
      tick;
      tests++;
      if ({we, be} !== {1'b1, 4'h0}) begin
         fails++;
         $display("FAIL be_zero_we: got we=%b be=%h, required 1 0", we, be);
      end
      tick; tick;
      tests++;
      if ({m0_ack, m0_rdata} !== {1'b1, 32'h1234ABCD}) begin
         fails++;
         $display("FAIL hold_write: got ack=%b rdata=%h, required 1 1234abcd", m0_ack, m0_rdata);
      end
      m0_req = 0;
      tick;
   endtask

   task automatic test_random;
      int ph = 0, st0 = 0, st1 = 0;
      logic mo = 0, lastg = 1, tw = 0;
      logic [7:0] ta = 0;
      logic [3:0] tbe = 0;
      logic [31:0] td = 0, r0 = 0, r1 = 0;
      logic [112:0] act, ex;
      do_reset;
      for (int i = 0; i < 800; i++) begin
         q = $urandom;
         // reference timeline: grant edge, then issue / wait / done cycles
         if (ph == 0) begin
            if (m0_req || m1_req) begin
               mo = (m0_req && m1_req) ? !lastg : m1_req;
               lastg = mo;
               tw = mo ? m1_we : m0_we;
               ta = mo ? m1_addr : m0_addr;
               tbe = mo ? m1_be : m0_be;
               td = mo ? m1_wdata : m0_wdata;
               ph = 1;
            end
         end else begin
            if (ph == 2 && !tw) begin
               if (mo) r1 = q;
               else r0 = q;
            end
            ph = (ph == 3) ? 0 : ph + 1;
         end
         tick;
         ex = {ph == 1 && tw, (ph == 1 || ph == 2) ? ta : 8'h0, (ph == 1 || ph == 2) ? tbe : 4'h0,
               (ph == 1 || ph == 2) ? td : 32'h0, ph == 3 && !mo, ph == 3 && mo, r0, r1, ph != 0, mo};
         act = {we, addr, be, wdata, m0_ack, m1_ack, m0_rdata, m1_rdata, busy, owner};
         tests++;
         if (act !== ex) begin
            fails++;
            $display("FAIL random cyc=%0d: got %h required %h", i, act, ex);
         end
         if (m0_ack) begin
            tests++;
            if (cyc - st0 > 7 || cyc - st0 < 3) begin
               fails++;
               $display("FAIL m0_wait: got latency %0d, required 3..7", cyc - st0);
            end
         end
         if (m1_ack) begin
            tests++;
            if (cyc - st1 > 7 || cyc - st1 < 3) begin
               fails++;
               $display("FAIL m1_wait: got latency %0d, required 3..7", cyc - st1);
            end
         end
         if (ph == 3 && !mo) m0_req = 0;
         else if (!m0_req && $urandom_range(0, 2) == 0) begin
            m0_we = 1'($urandom_range(0, 1)); m0_addr = 8'($urandom); m0_be = 4'($urandom);
            m0_wdata = $urandom; m0_req = 1; st0 = cyc;
         end
         if (ph == 3 && mo) m1_req = 0;
         else if (!m1_req && $urandom_range(0, 2) == 0) begin
            m1_we = 1'($urandom_range(0, 1)); m1_addr = 8'($urandom); m1_be = 4'($urandom);
            m1_wdata = $urandom; m1_req = 1; st1 = cyc;
         end
      end
      m0_req = 0; m1_req = 0;
   endtask

   initial begin
      test_reset;
      test_single_write;
      test_single_read;
      test_contention;
      test_late_requester;
      test_async_reset;
      test_rdata_hold;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
